// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32 funct3 codes, FSM state
// encoding and lane-width helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] MERGE = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    // Stores only have the signed-looking codes; LBU/LHU have no store twin.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        return ((f3[1:0] == 2'b01) && addr_lo[0]) ||
               ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data from a memory word and
// merges sub-word store data into the old word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [BYTE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;

    // Half lane uses addr[1] only, so addr[0] is naturally ignored for halves.
    always_comb begin
        byte_lane = rdata_word[8*addr_lo +: BYTE_W];
        half_lane = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   load_data = {24'd0, byte_lane};
            F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
            F3_HU:   load_data = {16'd0, half_lane};
            default: load_data = rdata_word;
        endcase
    end

    always_comb begin
        merge_data = rdata_word;
        case (funct3[1:0])
            2'b00:   merge_data[8*addr_lo +: BYTE_W] = wdata[7:0];
            2'b01:   merge_data[16*addr_lo[1] +: HALF_W] = wdata[15:0];
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-indexed data memory: sub-word loads are
// extended, sub-word stores become read-modify-write. Optional macro
// MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int MEM_IDX_W = 5,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [31:0]     mem_addr,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    logic [2:0]           state;
    logic [MEM_IDX_W+1:0] addr_q;
    logic                 we_q;
    logic [2:0]           f3_q;
    logic [XLEN-1:0]      wdata_q;
    logic [XLEN-1:0]      word_q;
    logic                 err_q;
    logic                 bad;
    logic [XLEN-1:0]      load_data;
    logic [XLEN-1:0]      merge_data;

    // Upper address bits only select beyond the memory, so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:MEM_IDX_W+2];

    always_comb begin
`ifdef MISALIGN_TRAP_EN
        bad = !f3_legal(req_we, req_funct3) || f3_misaligned(req_funct3, req_addr[1:0]);
`else
        bad = !f3_legal(req_we, req_funct3);
`endif
    end

    lsu_align u_align (
        .rdata_word (mem_rdata),
        .wdata      (wdata_q),
        .addr_lo    (addr_q[1:0]),
        .funct3     (f3_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            wdata_q <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q  <= req_addr[MEM_IDX_W+1:0];
                    we_q    <= req_we;
                    f3_q    <= req_funct3;
                    wdata_q <= req_wdata;
                    err_q   <= bad;
                    word_q  <= '0;
                    if (bad)                   state <= RESP;
                    else if (!req_we)          state <= LOAD;
                    else if (req_funct3 == F3_W) begin
                        word_q <= req_wdata;
                        state  <= WRITE;
                    end else                   state <= MERGE;
                end
                LOAD: begin
                    word_q <= load_data;
                    state  <= RESP;
                end
                MERGE: begin
                    word_q <= merge_data;
                    state  <= WRITE;
                end
                WRITE:   state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) && err_q;
        resp_rdata = ((state == RESP) && !we_q && !err_q) ? word_q : '0;
        mem_read   = (state == LOAD) || (state == MERGE);
        mem_write  = (state == WRITE);
        mem_wdata  = (state == WRITE) ? word_q : '0;
        mem_addr   = (state != IDLE) ? {{(30 - MEM_IDX_W){1'b0}}, addr_q[MEM_IDX_W+1:2]} : 32'd0;
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed self-checking bench for lsu_rmw with a 32-word behavioural memory.
// Expectations follow MISALIGN_TRAP_EN when it is defined.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [32] = '{default: 32'd0};
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_rmw dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[4:0]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[4:0]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it to its response, counting latency from
  // the accept edge and the memory strobes seen on the way.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input int exp_reads, input int exp_writes,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    int reads;
    int writes;
    bit seen;
    bit both;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; reads = 0; writes = 0; seen = 0; both = 0;
    while (lat <= 8 && !seen) begin
      if (mem_read && mem_write) both = 1;
      reads  += int'(mem_read);
      writes += int'(mem_write);
      if (resp_valid) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    check({tag, "_reads"}, 32'(reads), 32'(exp_reads));
    check({tag, "_writes"}, 32'(writes), 32'(exp_writes));
    check({tag, "_rw_both"}, 32'(both), 32'd0);
    check({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    // clock/reset
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;

    do_req("sw8", 1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 2, 0, 1, 32'd0, 1'b0);
    check("mem2_sw", mem[2], 32'hDEAD_BEEF);
    do_req("lw8", 1'b0, 3'b010, 32'h8, 32'd0, 2, 1, 0, 32'hDEAD_BEEF, 1'b0);
    do_req("lb_b", 1'b0, 3'b000, 32'hB, 32'd0, 2, 1, 0, 32'hFFFF_FFDE, 1'b0);
    do_req("lbu_b", 1'b0, 3'b100, 32'hB, 32'd0, 2, 1, 0, 32'h0000_00DE, 1'b0);
    do_req("lh_a", 1'b0, 3'b001, 32'hA, 32'd0, 2, 1, 0, 32'hFFFF_DEAD, 1'b0);
    do_req("lhu_8", 1'b0, 3'b101, 32'h8, 32'd0, 2, 1, 0, 32'h0000_BEEF, 1'b0);
    do_req("lb_9", 1'b0, 3'b000, 32'h9, 32'd0, 2, 1, 0, 32'hFFFF_FFBE, 1'b0);
    do_req("lw_wrap", 1'b0, 3'b010, 32'h8000_0088, 32'd0, 2, 1, 0, 32'hDEAD_BEEF, 1'b0);

    do_req("sw_c", 1'b1, 3'b010, 32'hC, 32'h1122_3344, 2, 0, 1, 32'd0, 1'b0);
    do_req("sb_d", 1'b1, 3'b000, 32'hD, 32'hFFFF_FFAA, 3, 1, 1, 32'd0, 1'b0);
    check("mem3_sb", mem[3], 32'h1122_AA44);
    do_req("sh_e", 1'b1, 3'b001, 32'hE, 32'h1234_5566, 3, 1, 1, 32'd0, 1'b0);
    check("mem3_sh", mem[3], 32'h5566_AA44);

    do_req("ld_f3_011", 1'b0, 3'b011, 32'h8, 32'd0, 1, 0, 0, 32'd0, 1'b1);
    do_req("st_f3_100", 1'b1, 3'b100, 32'h8, 32'h0, 1, 0, 0, 32'd0, 1'b1);
    check("mem2_after_err", mem[2], 32'hDEAD_BEEF);

    // Back-to-back: valid stays high across the first transaction.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'hC;
    check("b2b_ready_load", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("b2b_resp1", 32'(resp_valid), 32'd1);
    check("b2b_rdata1", resp_rdata, 32'hDEAD_BEEF);
    check("b2b_ready_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("b2b_ready_idle", 32'(req_ready), 32'd1);
    check("b2b_no_resp_idle", 32'(resp_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_ready_load2", 32'(req_ready), 32'd0);
    check("b2b_read2", 32'(mem_read), 32'd1);
    @(negedge clk);
    check("b2b_resp2", 32'(resp_valid), 32'd1);
    check("b2b_rdata2", resp_rdata, 32'h5566_AA44);

    // Reset asserted during the WRITE cycle of an SB must not land the write.
    do_req("sw_4", 1'b1, 3'b010, 32'h4, 32'h0BAD_F00D, 2, 0, 1, 32'd0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h4; req_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rmw_merge_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    check("rmw_in_write", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    check("rstw_mem_write", 32'(mem_write), 32'd0);
    check("rstw_ready", 32'(req_ready), 32'd1);
    check("rstw_outputs", {28'd0, resp_valid, resp_err, mem_read, mem_write}, 32'd0);
    check("rstw_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mem1_after_rst", mem[1], 32'h0BAD_F00D);

`ifdef MISALIGN_TRAP_EN
    do_req("lw_6", 1'b0, 3'b010, 32'h6, 32'd0, 1, 0, 0, 32'd0, 1'b1);
    do_req("sh_5", 1'b1, 3'b001, 32'h5, 32'h9999, 1, 0, 0, 32'd0, 1'b1);
    check("mem1_after_trap", mem[1], 32'h0BAD_F00D);
`else
    do_req("lw_6", 1'b0, 3'b010, 32'h6, 32'd0, 2, 1, 0, 32'h0BAD_F00D, 1'b0);
    do_req("lhu_7", 1'b0, 3'b101, 32'h7, 32'd0, 2, 1, 0, 32'h0000_0BAD, 1'b0);
`endif

    // final report
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit sitting directly upstream of data_memory in the MEM stage.
- Converts RV32 byte, halfword and word loads/stores into whole-word accesses on the word-indexed data memory:
  - sign/zero-extends load data;
  - performs read-modify-write for sub-word stores, because the memory only writes full words.
- Valid/ready handshake toward the pipeline; one request in flight at a time.

Parameters:
- MEM_IDX_W, 5, number of word-index bits driven to data memory (default gives 32 words).
- XLEN, 32, data width; fixed at 32 (sub-word lane logic assumes 4 bytes).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32 funct3 of the load/store.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data (rs2).
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  illegal funct3, or misaligned (see optional feature).
- mem_addr  output  32  word index: zero-extended req_addr[MEM_IDX_W+1:2].
- mem_read  output  1  read enable to data memory.
- mem_write  output  1  write enable to data memory.
- mem_wdata  output  32  full word to write.
- mem_rdata  input  32  combinational read data from memory.

Behaviour:
- Reset values: all outputs 0 except req_ready=1; state=IDLE; internal regs cleared.
- Reset is asynchronous: mid-operation it returns to IDLE at once; mem_write drops immediately, so no partial write lands.
- Request is accepted on a rising edge with req_valid&&req_ready. addr, we, funct3 and wdata are latched.
- Legal funct3 values:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000 SB, 001 SH, 010 SW.
  - Any other value gives resp_err=1 with no memory access.
- States:
  - IDLE: req_ready=1.
    - Illegal/misaligned request → RESP with err.
    - Load → LOAD.
    - SW → WRITE.
    - SB/SH → MERGE.
  - LOAD: mem_read=1. Select byte lane addr[1:0] or half lane addr[1], extend, register into rdata → RESP.
  - MERGE: mem_read=1. Replace the addressed byte/half of mem_rdata with wdata[7:0]/[15:0] into the merge reg → WRITE.
  - WRITE: mem_write=1, mem_wdata=merge reg (SW: latched wdata) → RESP. Memory updates at the end of this cycle.
  - RESP: resp_valid=1 for exactly one cycle, resp_rdata/resp_err valid → IDLE.
- req_ready=0 in every state except IDLE; a request arriving during RESP waits one cycle.
- Latency, counted from the accept edge to resp_valid high:
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles;
  - error: 1 cycle.
- mem_addr is held from the registered address in every non-IDLE state. mem_read and mem_write are never both 1.
- Address bits above MEM_IDX_W+1 are ignored; accesses wrap modulo the memory size.
- Extension rules:
  - LB/LH sign-extend bit 7/15;
  - LBU/LHU zero-extend;
  - LW passes the word through.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, give resp_err=1 with no memory access.
  - resp_rdata=0 in that case.
- Undefined:
  - low address bits are truncated to natural alignment (half: addr[0] ignored; word: addr[1:0] ignored);
  - the access proceeds normally and resp_err reports only illegal funct3.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state encoding (IDLE, LOAD, MERGE, WRITE, RESP);
  - size/extension helper constants.
- One natural sub-module, lsu_align: purely combinational.
  - Load lane extract/extend: mem_rdata, addr[1:0], funct3 → rdata.
  - Store merge: old word, wdata, addr[1:0], funct3 → new word.
- Top module holds the FSM and registers.

Test Plan:
- SW addr 0x0000_0008, data 0xDEAD_BEEF, then LW 0x8 → memory word[2]=0xDEADBEEF; resp_rdata=0xDEADBEEF; each response 2 cycles after accept.
- Word[2]=0xDEADBEEF; LB 0xB → 0xFFFF_FFDE. LBU 0xB → 0x0000_00DE. LH 0xA → 0xFFFF_DEAD. LHU 0x8 → 0x0000_BEEF.
- Word[3]=0x1122_3344; SB 0xD data 0xAA → word[3]=0x1122_AA44. SH 0xE data 0x5566 → 0x5566_AA44. Response 3 cycles after accept; mem_write high for exactly one cycle.
- Back-to-back req_valid held high → second request is accepted only on the cycle after resp_valid; req_ready low throughout.
- funct3=011 load → resp_err=1 one cycle after accept; mem_read/mem_write never asserted.
- rst pulsed during WRITE of SB 0x4 → word[1] unchanged, outputs at reset values, req_ready=1. With MISALIGN_TRAP_EN: LW 0x6 → resp_err=1. Without: LW 0x6 returns word[1].
